// File: rtl/trace_recorder.sv
// Commit-trace capture unit: records one entry per committed instruction into a
// first-word-fall-through FIFO and detects the end-of-program halt instruction.
module trace_recorder #(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 16,
  parameter int                MIN_COMMITS = 20,
  parameter logic [DATA_W-1:0] HALT_INST   = {DATA_W{1'b0}},
  parameter int                CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       mode,
  input  logic                       commit_valid,
  input  logic [DATA_W-1:0]          commit_pc,
  input  logic [DATA_W-1:0]          commit_inst,
  input  logic                       rf_we,
  input  logic [4:0]                 rf_waddr,
  input  logic [DATA_W-1:0]          rf_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_inst,
  output logic [DATA_W-1:0]          out_wdata,
  output logic                       out_we,
  output logic [4:0]                 out_waddr,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       running,
  output logic                       halted,
  output logic [CNT_W-1:0]           commits,
  output logic [CNT_W-1:0]           dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_COMMITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              we;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [CNT_W-1:0]  commits_q, commits_d, dropped_q, dropped_d;
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];

  entry_t new_entry_s, head_s;
  logic   pop_s, full_s, capture_s, halt_match_s, push_s;

  assign new_entry_s  = '{pc: commit_pc, inst: commit_inst, we: rf_we,
                          waddr: rf_waddr, wdata: rf_wdata};
  assign head_s       = mem_q[rd_ptr_q];
  assign full_s       = (level_q == FULL_LVL);
  assign pop_s        = (level_q != {LW{1'b0}}) && out_ready;
  assign capture_s    = (state_q == S_RUN) && commit_valid;
  assign halt_match_s = capture_s && (commits_q >= MIN_C) && (commit_inst == HALT_INST);
  assign push_s       = capture_s && !halt_match_s;

  // Next-state for run control, counters and FIFO bookkeeping.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    commits_d = commits_q;
    dropped_d = dropped_q;
    mem_d     = mem_q;
    if (clear) begin
      state_d   = S_IDLE;
      wr_ptr_d  = {AW{1'b0}};
      rd_ptr_d  = {AW{1'b0}};
      level_d   = {LW{1'b0}};
      commits_d = {CNT_W{1'b0}};
      dropped_d = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_d   = S_RUN;
            commits_d = {CNT_W{1'b0}};
          end else begin
            state_d = state_q;
          end
        end
        S_RUN: begin
          if (halt_match_s) begin
            state_d = S_HALT;
          end else if (push_s) begin
            commits_d = sat_inc(commits_q);
          end else begin
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // A pop frees the slot the same cycle, so push-with-pop never overflows.
      if (push_s && (!full_s || pop_s)) begin
        mem_d[wr_ptr_q] = new_entry_s;
        wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        if (pop_s) begin
          rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
          level_d = level_q + {{(LW-1){1'b0}}, 1'b1};
        end
      end else if (push_s) begin
        dropped_d = sat_inc(dropped_q);
        if (mode) begin
          mem_d[wr_ptr_q] = new_entry_s;
          wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
          rd_ptr_d        = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
          mem_d = mem_q;
        end
      end else if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        level_d  = level_q - {{(LW-1){1'b0}}, 1'b1};
      end else begin
        level_d = level_q;
      end
    end
  end

  // State, pointer, counter and storage registers; storage is reset-cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      level_q   <= {LW{1'b0}};
      commits_q <= {CNT_W{1'b0}};
      dropped_q <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      commits_q <= commits_d;
      dropped_q <= dropped_d;
      mem_q     <= mem_d;
    end
  end

  assign out_valid = (level_q != {LW{1'b0}});
  assign out_pc    = head_s.pc;
  assign out_inst  = head_s.inst;
  assign out_we    = head_s.we;
  assign out_waddr = head_s.waddr;
  assign out_wdata = head_s.wdata;
  assign level     = level_q;
  assign running   = (state_q == S_RUN);
  assign halted    = (state_q == S_HALT);
  assign commits   = commits_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_trace_recorder.sv
// Self-checking bench for trace_recorder: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_trace_recorder;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int MINC   = 20;
  localparam int CNT_W  = 16;
  localparam logic [31:0] HALT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, clear = 1'b0, mode = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = 32'h0, commit_inst = 32'h0, rf_wdata = 32'h0;
  logic        rf_we = 1'b0;
  logic [4:0]  rf_waddr = 5'd0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_we, running, halted;
  logic [31:0] out_pc, out_inst, out_wdata;
  logic [4:0]  out_waddr;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic [CNT_W-1:0] commits, dropped;

  int checks = 0;
  int failures = 0;

  ent_t mq[$];
  int   m_state = 0;     // 0 idle, 1 run, 2 halt
  int   m_commits = 0;
  int   m_dropped = 0;

  trace_recorder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MIN_COMMITS(MINC),
                   .HALT_INST(HALT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst_n), .start(start), .clear(clear), .mode(mode),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_wdata(out_wdata), .out_we(out_we),
    .out_waddr(out_waddr), .level(level), .running(running), .halted(halted),
    .commits(commits), .dropped(dropped));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue semantics, updated on each rising edge.
  initial begin : model
    int   old;
    bit   do_pop, do_push;
    ent_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || clear) begin
        mq.delete();
        m_state = 0; m_commits = 0; m_dropped = 0;
      end else begin
        old     = m_state;
        do_pop  = (mq.size() > 0) && out_ready;
        do_push = 1'b0;
        e = '{pc: commit_pc, inst: commit_inst, we: rf_we, waddr: rf_waddr, wdata: rf_wdata};
        if (old == 1 && commit_valid) begin
          if (m_commits >= MINC && commit_inst == HALT) m_state = 2;
          else begin
            if (m_commits < (1 << CNT_W) - 1) m_commits++;
            do_push = 1'b1;
          end
        end
        if (old != 1 && start) begin
          m_state = 1; m_commits = 0;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          if (mq.size() < DEPTH) mq.push_back(e);
          else begin
            if (m_dropped < (1 << CNT_W) - 1) m_dropped++;
            if (mode) begin
              void'(mq.pop_front());
              mq.push_back(e);
            end
          end
        end
      end
    end
  end

  // Compare process: every falling edge, DUT versus model.
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("out_valid", out_valid, mq.size() != 0);
      chk("level", level, mq.size());
      chk("running", running, m_state == 1);
      chk("halted", halted, m_state == 2);
      chk("commits", commits, m_commits);
      chk("dropped", dropped, m_dropped);
      if (mq.size() > 0) begin
        chk("head_pc", out_pc, mq[0].pc);
        chk("head_inst", out_inst, mq[0].inst);
        chk("head_we", out_we, mq[0].we);
        chk("head_waddr", out_waddr, mq[0].waddr);
        chk("head_wdata", out_wdata, mq[0].wdata);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_commit(input logic [31:0] pc, input logic [31:0] inst,
                           input logic we, input logic [4:0] wa, input logic [31:0] wd);
    commit_valid = 1'b1; commit_pc = pc; commit_inst = inst;
    rf_we = we; rf_waddr = wa; rf_wdata = wd;
    cyc();
    commit_valid = 1'b0;
  endtask

  task automatic restart();
    clear = 1'b1; cyc(); clear = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      do_commit(base + 32'(4 * i), 32'h2400_0000 + 32'(i + 1), i[0], i[4:0], ~base ^ 32'(i));
  endtask

  initial begin : stim
    logic [31:0] inst;
    repeat (3) cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_running", running, 0);
    chk("rst_halted", halted, 0);
    chk("rst_commits", commits, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_wdata", out_wdata, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_out_waddr", out_waddr, 0);
    rst_n = 1'b1; cyc();

    // Basic capture then in-order drain
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 3; i++)
      do_commit(32'h0040_0000 + 32'(4 * i), 32'h2108_0001 + 32'(i), 1'b1, 5'd8, 32'(100 + i));
    chk("basic_level", level, 3);
    chk("basic_head", out_pc, 32'h0040_0000);
    chk("basic_waddr", out_waddr, 8);
    out_ready = 1'b1;
    chk("drain0", out_pc, 32'h0040_0000); cyc();
    chk("drain1", out_pc, 32'h0040_0004); cyc();
    chk("drain2", out_pc, 32'h0040_0008); cyc();
    chk("drain_empty", out_valid, 0);
    out_ready = 1'b0;

    // Halt qualification: commit 10 too early, commit 23 ends the run
    restart();
    for (int n = 1; n <= 25; n++) begin
      inst = (n == 10 || n == 23) ? 32'h0 : 32'h0800_0000 + 32'(n);
      do_commit(32'h0040_1000 + 32'(4 * n), inst, 1'b1, 5'(n), 32'(n));
      if (n == 10) begin
        chk("halt10_halted", halted, 0);
        chk("halt10_commits", commits, 10);
      end
      if (n == 23) begin
        chk("halt23_halted", halted, 1);
        chk("halt23_commits", commits, 22);
      end
    end
    chk("halt_level", level, 16);
    chk("halt_dropped", dropped, 6);
    chk("halt_commits_final", commits, 22);
    start = 1'b1; cyc(); start = 1'b0;
    chk("rerun_running", running, 1);
    chk("rerun_level", level, 16);
    chk("rerun_commits", commits, 0);

    // Full, mode 0: drop newest
    restart();
    mode = 1'b0;
    fill(32'h0040_2000, DEPTH + 3);
    chk("m0_level", level, 16);
    chk("m0_dropped", dropped, 3);
    chk("m0_head", out_pc, 32'h0040_2000);

    // Full with push and pop every cycle
    restart();
    fill(32'h0040_3000, DEPTH);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++)
      do_commit(32'h0040_3800 + 32'(4 * i), 32'h0C00_0000 + 32'(i), 1'b0, 5'd3, 32'(i));
    out_ready = 1'b0;
    chk("pp_level", level, 16);
    chk("pp_dropped", dropped, 0);
    chk("pp_head", out_pc, 32'h0040_3028);

    // Full, mode 1: overwrite oldest
    restart();
    mode = 1'b1;
    fill(32'h0040_4000, DEPTH + 3);
    chk("m1_level", level, 16);
    chk("m1_dropped", dropped, 3);
    chk("m1_head", out_pc, 32'h0040_400C);
    out_ready = 1'b1;
    repeat (15) cyc();
    chk("m1_tail_level", level, 1);
    chk("m1_tail", out_pc, 32'h0040_4048);
    cyc();
    chk("m1_empty", out_valid, 0);
    out_ready = 1'b0;
    mode = 1'b0;

    // Asynchronous reset mid-run
    restart();
    fill(32'h0040_5000, 5);
    chk("ar_level_before", level, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_level", level, 0);
    chk("ar_running", running, 0);
    chk("ar_commits", commits, 0);
    chk("ar_out_pc", out_pc, 0);
    chk("ar_out_inst", out_inst, 0);
    cyc();
    rst_n = 1'b1; cyc();
    start = 1'b1; cyc(); start = 1'b0;
    chk("ar_restart_running", running, 1);
    chk("ar_restart_commits", commits, 0);
    do_commit(32'h0040_6000, 32'h1234_5678, 1'b1, 5'd9, 32'hCAFE_0001);
    chk("ar_post_commits", commits, 1);
    chk("ar_post_level", level, 1);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_recorder.md
# trace_recorder

Synthesizable commit-trace capture unit for the single-cycle MIPS core. It sits beside the CPU and records one entry per committed instruction (PC, instruction word, register-file write) into an on-chip FIFO that a debug/UART drain reads through a valid/ready port. It detects the end-of-program condition in hardware: a halt instruction seen after a minimum number of commits. Depth, width, halt criteria and full-buffer policy are parametrised or mode-selectable.

## Interface
- `DATA_W`, 32: width of PC, instruction and write-data fields.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `MIN_COMMITS`, 20: commits required before a halt match may end the run.
- `HALT_INST`, 32'h00000000: instruction word that ends the run.
- `CNT_W`, 16: width of the `commits` and `dropped` counters.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; IDLE/HALT → RUN.
- `clear` in 1: synchronous flush to IDLE; priority over all other inputs.
- `mode` in 1: 0 = drop-new when full; 1 = overwrite-oldest when full.
- `commit_valid` in 1: one instruction commits this cycle.
- `commit_pc` in DATA_W: PC of the committing instruction.
- `commit_inst` in DATA_W: instruction word.
- `rf_we` in 1: register-file write enable.
- `rf_waddr` in 5: destination register.
- `rf_wdata` in DATA_W: write data.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts the head entry.
- `out_pc`, `out_inst`, `out_wdata` out DATA_W each; `out_we` out 1; `out_waddr` out 5: head entry.
- `level` out $clog2(DEPTH+1): entries held.
- `running` out 1; `halted` out 1: state flags.
- `commits` out CNT_W; `dropped` out CNT_W: saturating counters.

## Operation
- States: IDLE, RUN, HALT. Reset and `clear` enter IDLE with empty FIFO and zeroed counters.
- IDLE: no capture. `start` → RUN and zeroes `commits`.
- RUN, on `commit_valid`:
  - Halt match when `commits >= MIN_COMMITS` and `commit_inst == HALT_INST`. The state goes to HALT, the entry is not stored, and `commits` is unchanged.
  - Otherwise `commits` increments, saturating at all-ones, and the entry is pushed.
- Push when not full: write at `wr_ptr`, advance it.
- Push when full and no pop:
  - mode 0: entry discarded, `dropped` increments.
  - mode 1: entry written at `wr_ptr`, both pointers advance so the oldest entry is lost; `dropped` increments.
- Push and pop in the same cycle always succeed in both modes. `level` is unchanged and `dropped` does not increment.
- Pop: `out_valid && out_ready` advances `rd_ptr`. A pop when empty is ignored.
- HALT: no capture, draining continues. `start` → RUN keeps FIFO contents and zeroes `commits`.
- `start` in RUN is ignored. `mode` may change at any time and takes effect at the next push.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty is derived from `level`.
- `dropped` saturates at all-ones.

## Timing
- Reset values:
  - `out_valid`=0, `level`=0, `running`=0, `halted`=0, `commits`=0, `dropped`=0.
  - Entry outputs are 0, because storage is reset-cleared.
- Capture latency is one cycle. A commit at edge N gives `out_valid`/`level` at N+1.
- Output is first-word-fall-through: head fields are combinational from storage at `rd_ptr`.
- Head fields are stable while `out_valid && !out_ready`. The one exception is a mode-1 overwrite while full, where the head advances.
- `running`/`halted` reflect the state register: the HALT transition is visible the cycle after the matching commit.
- `clear` with `start` in the same cycle: `clear` wins, result is IDLE.
- `reset` asserted mid-operation clears everything asynchronously. Release is synchronised by the integrator.

## Test plan
- Basic capture: reset, `start`, 3 commits with PCs 0x00400000/04/08, `rf_we`=1, `rf_waddr`=8, `out_ready`=0 → `level`=3, head PC 0x00400000. Raise `out_ready` → entries appear in order over 3 cycles, then `out_valid`=0.
- Halt qualification: 25 commits whose 10th and 23rd have `commit_inst`=0.
  - Commit 10: stored, no halt.
  - Commit 23: `halted`=1 next cycle, `commits`=22.
  - Further commits: ignored.
- Full, mode 0: DEPTH+3 commits with no pop → `level`=DEPTH, `dropped`=3, head is the first entry.
- Full, mode 1: DEPTH+3 commits with no pop → `level`=DEPTH, `dropped`=3, head is the 4th entry, tail is the last entry.
- Full with simultaneous push and pop every cycle for 10 cycles → `level` stays DEPTH, `dropped`=0, output order preserved.
- Asynchronous reset mid-run, 5 entries held → all outputs 0 immediately. `start` afterwards → `commits` restarts from 0.
